// File: rtl/fun_rdy_ctl.sv
// Functional-unit availability controller for the issue stage: tracks multiplier and
// address-unit occupancy, gates readiness on execute stall, aborts on flush, flags bad issues.
module fun_rdy_ctl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mul_ins_vld,
    input  logic       alu1_ins_vld,
    input  logic       alu2_ins_vld,
    input  logic       adr_ins_vld,
    input  logic       mem_ack,
    input  logic       stall_frm_exe,
    input  logic       flush,
    output logic [3:0] fun_rdy_frm_exe,
    output logic       mul_done,
    output logic [3:0] iss_err
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mul_st_e;

    typedef enum logic {
        A_IDLE = 1'b0,
        A_WAIT = 1'b1
    } adr_st_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_st_e          mul_st_q, mul_st_d;
    adr_st_e          adr_st_q, adr_st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rdy_q, rdy_d;
    logic             done_q, done_d;
    logic [3:0]       err_q, err_d;
    logic [3:0]       vld_s;
    logic [3:0]       acc_s;

    assign vld_s = {adr_ins_vld, alu2_ins_vld, alu1_ins_vld, mul_ins_vld};
    assign acc_s = vld_s & rdy_q;

    // Multiplier occupancy; the counter holds the busy cycles still remaining before M_DONE.
    always_comb begin
        mul_st_d = mul_st_q;
        cnt_d    = cnt_q;
        if (flush) begin
            mul_st_d = M_IDLE;
            cnt_d    = '0;
        end else begin
            case (mul_st_q)
                M_IDLE: begin
                    if (acc_s[0]) begin
                        if (MUL_LAT > 2) begin
                            mul_st_d = M_BUSY;
                            cnt_d    = CNT_LOAD;
                        end else begin
                            mul_st_d = M_DONE;
                            cnt_d    = '0;
                        end
                    end else begin
                        mul_st_d = M_IDLE;
                    end
                end
                M_BUSY: begin
                    if (cnt_q <= CNT_ONE) begin
                        mul_st_d = M_DONE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                M_DONE: begin
                    mul_st_d = M_IDLE;
                    cnt_d    = '0;
                end
                default: begin
                    mul_st_d = M_IDLE;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    // Address unit stays blocked from issue until memory acknowledges.
    always_comb begin
        adr_st_d = adr_st_q;
        if (flush) begin
            adr_st_d = A_IDLE;
        end else begin
            case (adr_st_q)
                A_IDLE: begin
                    if (acc_s[3]) begin
                        adr_st_d = A_WAIT;
                    end else begin
                        adr_st_d = A_IDLE;
                    end
                end
                A_WAIT: begin
                    if (mem_ack) begin
                        adr_st_d = A_IDLE;
                    end else begin
                        adr_st_d = A_WAIT;
                    end
                end
                default: adr_st_d = A_IDLE;
            endcase
        end
    end

    // Outputs are derived from next state so they describe the coming cycle.
    always_comb begin
        rdy_d  = {(adr_st_d == A_IDLE), 1'b1, 1'b1, (mul_st_d == M_IDLE)} & {4{~stall_frm_exe}};
        done_d = (mul_st_d == M_DONE);
        err_d  = err_q | (vld_s & ~rdy_q);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_st_q <= M_IDLE;
            adr_st_q <= A_IDLE;
            cnt_q    <= '0;
            rdy_q    <= 4'b1111;
            done_q   <= 1'b0;
            err_q    <= 4'b0000;
        end else begin
            mul_st_q <= mul_st_d;
            adr_st_q <= adr_st_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign fun_rdy_frm_exe = rdy_q;
    assign mul_done        = done_q;
    assign iss_err         = err_q;

endmodule

// File: tb/tb_fun_rdy_ctl.sv
// Self-checking bench for fun_rdy_ctl: directed scenarios plus random traffic compared
// against a timeline reference model (multiply completion cycle, address-busy flag).
module tb_fun_rdy_ctl;

    localparam int MUL_LAT = 4;

    localparam logic [7:0] R    = 8'h80;
    localparam logic [7:0] FL   = 8'h40;
    localparam logic [7:0] ST   = 8'h20;
    localparam logic [7:0] ACK  = 8'h10;
    localparam logic [7:0] ADR  = 8'h08;
    localparam logic [7:0] MUL  = 8'h01;
    localparam logic [7:0] NONE = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mul_ins_vld = 1'b0;
    logic       alu1_ins_vld = 1'b0;
    logic       alu2_ins_vld = 1'b0;
    logic       adr_ins_vld = 1'b0;
    logic       mem_ack = 1'b0;
    logic       stall_frm_exe = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] fun_rdy_frm_exe;
    logic       mul_done;
    logic [3:0] iss_err;

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index, cycle in which the multiply completes, address busy.
    int         cyc = 0;
    int         mul_end = -1;
    bit         adr_busy = 1'b0;
    logic [3:0] e_rdy = 4'b1111;
    logic       e_done = 1'b0;
    logic [3:0] e_err = 4'b0000;

    always #5 clk = ~clk;

    fun_rdy_ctl #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mul_ins_vld     (mul_ins_vld),
        .alu1_ins_vld    (alu1_ins_vld),
        .alu2_ins_vld    (alu2_ins_vld),
        .adr_ins_vld     (adr_ins_vld),
        .mem_ack         (mem_ack),
        .stall_frm_exe   (stall_frm_exe),
        .flush           (flush),
        .fun_rdy_frm_exe (fun_rdy_frm_exe),
        .mul_done        (mul_done),
        .iss_err         (iss_err)
    );

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: {rst, flush, stall, mem_ack, adr, alu2, alu1, mul}.
    task automatic step(input logic [7:0] in);
        logic [3:0] vld;
        logic [3:0] acc;
        {rst, flush, stall_frm_exe, mem_ack,
         adr_ins_vld, alu2_ins_vld, alu1_ins_vld, mul_ins_vld} = in;
        vld = in[3:0];
        acc = vld & e_rdy;
        @(posedge clk);
        if (in[7]) begin
            mul_end  = -1;
            adr_busy = 1'b0;
            e_err    = 4'b0000;
            e_done   = 1'b0;
            e_rdy    = 4'b1111;
        end else begin
            e_err = e_err | (vld & ~e_rdy);
            if (in[6]) begin
                mul_end  = -1;
                adr_busy = 1'b0;
            end else begin
                if (acc[0]) mul_end = cyc + MUL_LAT - 1;
                if (acc[3]) adr_busy = 1'b1;
                else if (adr_busy && in[4]) adr_busy = 1'b0;
            end
            e_done = (mul_end == cyc + 1);
            e_rdy  = in[5] ? 4'b0000 : {!adr_busy, 1'b1, 1'b1, (mul_end < cyc + 1)};
        end
        cyc++;
        #1;
        check4("model_rdy", fun_rdy_frm_exe, e_rdy);
        check1("model_done", mul_done, e_done);
        check4("model_err", iss_err, e_err);
    endtask

    initial begin
        logic [7:0] r;

        // Reset then idle
        step(R);
        repeat (5) step(NONE);
        check4("idle_rdy", fun_rdy_frm_exe, 4'b1111);
        check4("idle_err", iss_err, 4'b0000);

        // Multiply latency: issue at T, done visible at T+3, ready again at T+4
        step(MUL);
        check1("mul_bit0_busy", fun_rdy_frm_exe[0], 1'b0);
        step(NONE);
        check1("mul_not_yet", mul_done, 1'b0);
        step(NONE);
        check1("mul_done_pulse", mul_done, 1'b1);
        check1("mul_bit0_in_done", fun_rdy_frm_exe[0], 1'b0);
        step(NONE);
        check1("mul_done_once", mul_done, 1'b0);
        check4("mul_rdy_back", fun_rdy_frm_exe, 4'b1111);

        // Address handshake: same-cycle ack ignored, later ack releases
        step(ADR | ACK);
        repeat (3) step(NONE);
        check4("adr_wait", fun_rdy_frm_exe, 4'b0111);
        step(ACK);
        check4("adr_released", fun_rdy_frm_exe, 4'b1111);

        // Stall overlay on an in-flight multiply
        step(MUL);
        step(NONE);
        step(ST);
        check4("stall_rdy0", fun_rdy_frm_exe, 4'b0000);
        check1("stall_mul_done", mul_done, 1'b1);
        repeat (3) step(ST);
        check4("stall_rdy_last", fun_rdy_frm_exe, 4'b0000);
        step(NONE);
        check4("stall_rdy_back", fun_rdy_frm_exe, 4'b1111);

        // Flush aborts both units
        step(MUL | ADR);
        step(FL);
        check4("flush_rdy", fun_rdy_frm_exe, 4'b1111);
        repeat (4) step(NONE);
        check4("flush_adr_stays", fun_rdy_frm_exe, 4'b1111);

        // Issue to a busy multiplier is flagged and sticky
        step(MUL);
        step(MUL);
        check4("illegal_err", iss_err, 4'b0001);
        step(NONE);
        check1("illegal_done", mul_done, 1'b1);
        repeat (3) step(NONE);
        check4("illegal_sticky", iss_err, 4'b0001);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)  r = r | ACK;
            if ($urandom_range(0, 5) == 0)  r = r | ST;
            if ($urandom_range(0, 15) == 0) r = r | FL;
            if ($urandom_range(0, 99) == 0) r = r | R;
            step(r);
        end

        // Only reset clears the error flags
        step(R);
        check4("final_err_clear", iss_err, 4'b0000);
        step(NONE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
